ula_op_driver: RTL
==================

// Module: ula_op_driver
// PURPOSE
//   Initiator side of the 8-bit ULA port: accepts an operation request (A, B, F) on a
//   valid/ready channel, drives the ULA operand/opcode inputs from registers, captures
//   Saida/FLAG_O and returns them on a valid/ready response channel. Sits between the
//   control path and one combinational ULA instance; also keeps a sticky overflow flag.
// PARAMETERS
//   BITS    8   operand/result width; must equal the attached ULA's BITS
//   CNT_W   8   width of overflow event counter (used only with ULA_DRV_OVF_COUNT_EN)
// PORTS
//   clock        in   1       rising-edge clock
//   reset        in   1       asynchronous, active-low reset
//   req_valid    in   1       request present
//   req_ready    out  1       driver can accept request
//   req_a        in   BITS    operand A (two's complement)
//   req_b        in   BITS    operand B (two's complement)
//   req_op       in   2       0=AND 1=OR 2=ADD 3=SUB (ULA F encoding)
//   ula_a        out  BITS    to ULA A
//   ula_b        out  BITS    to ULA B
//   ula_f        out  2       to ULA F
//   ula_saida    in   BITS    from ULA Saida
//   ula_flag_o   in   1       from ULA FLAG_O
//   rsp_valid    out  1       response present
//   rsp_ready    in   1       consumer accepts response
//   rsp_saida    out  BITS    captured result
//   rsp_flag_o   out  1       captured overflow/underflow flag
//   ovf_sticky   out  1       set by any captured flag, cleared by ovf_clr
//   ovf_clr      in   1       clear ovf_sticky (and counter)
//   ovf_count    out  CNT_W   only with ULA_DRV_OVF_COUNT_EN
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE; ula_a/ula_b/ula_f/rsp_saida=0; rsp_valid=0,
//     rsp_flag_o=0, ovf_sticky=0, ovf_count=0. In-flight transaction discarded, no rsp.
//   - FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//     IDLE:    req_ready=1. On req_valid&&req_ready at edge: latch req_a/b/op into
//              ula_a/b/f, go ISSUE. req_ready is 0 in every other state.
//     ISSUE:   ULA settle cycle; ula_* held stable; go CAPTURE unconditionally.
//     CAPTURE: at edge, rsp_saida<=ula_saida, rsp_flag_o<=ula_flag_o, rsp_valid<=1; go RESP.
//     RESP:    rsp_valid=1, rsp_* held stable while rsp_ready=0. On rsp_valid&&rsp_ready
//              at edge: rsp_valid<=0, go IDLE.
//   - Latency: request accepted at edge k -> rsp_valid high after edge k+2. Min request
//     spacing 4 cycles with rsp_ready tied 1. req_valid ignored outside IDLE.
//   - ula_* outputs only change on acceptance; held after completion (no toggling).
//   - ovf_sticky: set at CAPTURE edge when ula_flag_o=1. ovf_clr=1 clears; if ovf_clr and a
//     set occur on the same edge, set wins (sticky=1).
//   - Flag semantics are the ULA's: FLAG_O only for ADD/SUB signed overflow; AND/OR give 0.
//   - No arithmetic in this block; widths pass through unchanged.
// CONFIGURATION
//   ULA_DRV_OVF_COUNT_EN defined: ovf_count port present; increments by 1 at each CAPTURE
//     with ula_flag_o=1, saturates at 2**CNT_W-1 (no wrap); ovf_clr zeroes it; clr+inc on
//     same edge -> count=1.
//   Not defined: ovf_count port and counter absent; all other behaviour identical.
// TESTING
//   1 ADD req 0x7F,0x01,op=2 -> rsp_saida=0x80, rsp_flag_o=1, ovf_sticky=1, rsp 2 edges later
//   2 SUB req 0x80,0x01,op=3 -> rsp_saida=0x7F, rsp_flag_o=1; SUB 0x05,0x03 -> 0x02, flag 0
//   3 AND 0xF0,0x3C -> 0x30 flag 0; OR 0xF0,0x3C -> 0xFC flag 0; ovf_sticky unchanged
//   4 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_saida stable, req_ready=0, a second
//     req_valid ignored; rsp_ready=1 -> IDLE next edge, req_ready=1
//   5 reset low during ISSUE -> all outputs 0 immediately, no rsp_valid after release
//   6 ovf_clr on same edge as flagged CAPTURE -> ovf_sticky=1; with ULA_DRV_OVF_COUNT_EN,
//     CNT_W=2, 5 overflowing ADDs -> ovf_count=3 (saturated), clr -> 0

Source files
------------

// File: rtl/ula_op_driver.sv
// Registered initiator for one combinational 8-bit ULA: request in, operands out, result back.
// Latency: accept at edge k, rsp_valid high after edge k+2. Backpressure: req_ready only in IDLE; the response is held until rsp_ready.
// Optional overflow event counter with ovf_count port: define ULA_DRV_OVF_COUNT_EN.
module ula_op_driver #(
    parameter int BITS  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [BITS-1:0]  req_a,
    input  logic [BITS-1:0]  req_b,
    input  logic [1:0]       req_op,
    output logic [BITS-1:0]  ula_a,
    output logic [BITS-1:0]  ula_b,
    output logic [1:0]       ula_f,
    input  logic [BITS-1:0]  ula_saida,
    input  logic             ula_flag_o,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BITS-1:0]  rsp_saida,
    output logic             rsp_flag_o,
    output logic             ovf_sticky,
    input  logic             ovf_clr
`ifdef ULA_DRV_OVF_COUNT_EN
    ,
    output logic [CNT_W-1:0] ovf_count
`endif
);

    if (BITS < 1 || CNT_W < 1) begin : g_bad_param
        $error("ula_op_driver: BITS and CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [BITS-1:0] ula_a_q, ula_a_d;
    logic [BITS-1:0] ula_b_q, ula_b_d;
    logic [1:0]      ula_f_q, ula_f_d;
    logic [BITS-1:0] rsp_saida_q, rsp_saida_d;
    logic            rsp_flag_q, rsp_flag_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            ovf_sticky_q, ovf_sticky_d;

    logic accept;
    logic capture;
    logic rsp_done;
    logic ovf_set;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req_valid) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_RESP:    if (rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        req_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            S_CAPTURE: capture  = 1'b1;
            S_RESP:    rsp_done = rsp_ready;
            default: ;
        endcase
    end

    assign ovf_set = capture && ula_flag_o;

    // Operands change only on acceptance so the ULA sees a stable input for the whole transaction.
    always_comb begin
        ula_a_d      = ula_a_q;
        ula_b_d      = ula_b_q;
        ula_f_d      = ula_f_q;
        rsp_saida_d  = rsp_saida_q;
        rsp_flag_d   = rsp_flag_q;
        rsp_valid_d  = rsp_valid_q;
        ovf_sticky_d = ovf_sticky_q;
        if (accept) begin
            ula_a_d = req_a;
            ula_b_d = req_b;
            ula_f_d = req_op;
        end
        if (capture) begin
            rsp_saida_d = ula_saida;
            rsp_flag_d  = ula_flag_o;
            rsp_valid_d = 1'b1;
        end else if (rsp_done) begin
            rsp_valid_d = 1'b0;
        end
        // A new overflow event outranks a simultaneous clear.
        if (ovf_set) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ula_a_q      <= '0;
            ula_b_q      <= '0;
            ula_f_q      <= '0;
            rsp_saida_q  <= '0;
            rsp_flag_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_f_q      <= ula_f_d;
            rsp_saida_q  <= rsp_saida_d;
            rsp_flag_q   <= rsp_flag_d;
            rsp_valid_q  <= rsp_valid_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_f      = ula_f_q;
    assign rsp_saida  = rsp_saida_q;
    assign rsp_flag_o = rsp_flag_q;
    assign rsp_valid  = rsp_valid_q;
    assign ovf_sticky = ovf_sticky_q;

`ifdef ULA_DRV_OVF_COUNT_EN
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    // Saturating count; clear and increment together restart the count at one.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_set) begin
            if (ovf_clr) begin
                ovf_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (ovf_count_q != {CNT_W{1'b1}}) begin
                ovf_count_d = ovf_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (ovf_clr) begin
            ovf_count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

endmodule
